// File: rtl/knn_host_sequencer.sv
// Host-side command sequencer for the KNN classifier: turns a LOAD/CLASSIFY word stream into
// training-memory writes, test-feature beats and a returned result word.
module knn_host_sequencer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_FEATURES = 8,
  parameter int unsigned NUM_SAMPLES  = 100,
  parameter int unsigned LABEL_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned K            = 5,
  parameter int unsigned TIMEOUT      = 4096,
  localparam int unsigned CW = $clog2(K + 1),
  localparam int unsigned FW = $clog2(NUM_FEATURES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic [FW-1:0]          cfg_num_features,
  output logic                   train_mode,
  output logic                   train_sample_wen,
  output logic [ADDR_WIDTH-1:0]  train_sample_addr,
  output logic [DATA_WIDTH-1:0]  train_sample_data,
  output logic                   train_label_wen,
  output logic [ADDR_WIDTH-1:0]  train_label_addr,
  output logic [LABEL_WIDTH-1:0] train_label_data,
  output logic                   classify_start,
  output logic                   test_feature_valid,
  output logic [DATA_WIDTH-1:0]  test_feature_data,
  input  logic                   classifier_busy,
  input  logic                   classify_done,
  input  logic [LABEL_WIDTH-1:0] result_label,
  input  logic [CW-1:0]          result_confidence,
  output logic                   seq_busy,
  output logic                   err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = CW + LABEL_WIDTH;
  localparam logic [1:0] OpLoad     = 2'b00;
  localparam logic [1:0] OpClassify = 2'b01;

  typedef enum logic [3:0] {
    StIdle, StTSetup, StTFeat, StTLabel, StCStart, StCWaitBusy, StCFeat, StCWait, StResult
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [7:0]             count_q, count_d;
  logic [FW-1:0]          cfg_q, cfg_d;
  logic [FW-1:0]          feat_idx_q, feat_idx_d;
  logic [7:0]             sample_idx_q, sample_idx_d;
  logic [ADDR_WIDTH-1:0]  word_addr_q, word_addr_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [RW-1:0]          result_q, result_d;
  logic                   err_q, err_d;
  logic                   sw_wen_q, sw_wen_d;
  logic [ADDR_WIDTH-1:0]  sw_addr_q, sw_addr_d;
  logic [DATA_WIDTH-1:0]  sw_data_q, sw_data_d;
  logic                   lw_wen_q, lw_wen_d;
  logic [ADDR_WIDTH-1:0]  lw_addr_q, lw_addr_d;
  logic [LABEL_WIDTH-1:0] lw_data_q, lw_data_d;
  logic                   tf_valid_q, tf_valid_d;
  logic [DATA_WIDTH-1:0]  tf_data_q, tf_data_d;

  logic       accept;
  logic [1:0] hdr_op;
  logic [7:0] hdr_count;
  logic       feat_last;
  logic       timer_expired;

  assign accept        = in_valid & ready_q;
  assign hdr_op        = in_data[15:14];
  assign hdr_count     = in_data[7:0];
  assign feat_last     = (feat_idx_q == cfg_q - FW'(1));
  assign timer_expired = (timer_q >= TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cfg_d        = cfg_q;
    feat_idx_d   = feat_idx_q;
    sample_idx_d = sample_idx_q;
    word_addr_d  = word_addr_q;
    timer_d      = timer_q;
    result_d     = result_q;
    err_d        = 1'b0;
    sw_wen_d     = 1'b0;
    sw_addr_d    = sw_addr_q;
    sw_data_d    = sw_data_q;
    lw_wen_d     = 1'b0;
    lw_addr_d    = lw_addr_q;
    lw_data_d    = lw_data_q;
    tf_valid_d   = 1'b0;
    tf_data_d    = tf_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          count_d = hdr_count;
          cfg_d   = cfg_num_features;
          if (hdr_op == OpLoad && hdr_count != 8'd0 && 32'(hdr_count) <= NUM_SAMPLES &&
              cfg_num_features != '0) begin
            state_d = StTSetup;
          end else if (hdr_op == OpClassify && cfg_num_features != '0) begin
            state_d = StCStart;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StTSetup: begin
        word_addr_d  = '0;
        sample_idx_d = '0;
        feat_idx_d   = '0;
        state_d      = StTFeat;
      end
      StTFeat: begin
        if (accept) begin
          sw_wen_d    = 1'b1;
          sw_addr_d   = word_addr_q;
          sw_data_d   = in_data;
          word_addr_d = word_addr_q + ADDR_WIDTH'(1);
          if (feat_last) begin
            feat_idx_d = '0;
            state_d    = StTLabel;
          end else begin
            feat_idx_d = feat_idx_q + FW'(1);
          end
        end
      end
      StTLabel: begin
        if (accept) begin
          lw_wen_d  = 1'b1;
          lw_addr_d = ADDR_WIDTH'(sample_idx_q);
          lw_data_d = in_data[LABEL_WIDTH-1:0];
          if (sample_idx_q == count_q - 8'd1) begin
            state_d = StIdle;
          end else begin
            sample_idx_d = sample_idx_q + 8'd1;
            state_d      = StTFeat;
          end
        end
      end
      StCStart: begin
        feat_idx_d = '0;
        timer_d    = '0;
        state_d    = StCWaitBusy;
      end
      // The timeout budget covers waiting for busy and waiting for done; it pauses in StCFeat.
      StCWaitBusy: begin
        timer_d = timer_q + TW'(1);
        if (classifier_busy) begin
          state_d = StCFeat;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCFeat: begin
        if (accept) begin
          tf_valid_d = 1'b1;
          tf_data_d  = in_data;
          if (feat_last) begin
            feat_idx_d = '0;
            state_d    = StCWait;
          end else begin
            feat_idx_d = feat_idx_q + FW'(1);
          end
        end
      end
      StCWait: begin
        if (classify_done) begin
          result_d = {result_confidence, result_label};
          state_d  = StResult;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StResult: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Ready is registered from the next state so it stays low throughout reset.
    ready_d = (state_d inside {StIdle, StTFeat, StTLabel, StCFeat});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      count_q      <= '0;
      cfg_q        <= '0;
      feat_idx_q   <= '0;
      sample_idx_q <= '0;
      word_addr_q  <= '0;
      timer_q      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      sw_wen_q     <= 1'b0;
      sw_addr_q    <= '0;
      sw_data_q    <= '0;
      lw_wen_q     <= 1'b0;
      lw_addr_q    <= '0;
      lw_data_q    <= '0;
      tf_valid_q   <= 1'b0;
      tf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
      cfg_q        <= cfg_d;
      feat_idx_q   <= feat_idx_d;
      sample_idx_q <= sample_idx_d;
      word_addr_q  <= word_addr_d;
      timer_q      <= timer_d;
      result_q     <= result_d;
      err_q        <= err_d;
      sw_wen_q     <= sw_wen_d;
      sw_addr_q    <= sw_addr_d;
      sw_data_q    <= sw_data_d;
      lw_wen_q     <= lw_wen_d;
      lw_addr_q    <= lw_addr_d;
      lw_data_q    <= lw_data_d;
      tf_valid_q   <= tf_valid_d;
      tf_data_q    <= tf_data_d;
    end
  end

  assign in_ready           = ready_q;
  assign out_valid          = (state_q == StResult);
  assign out_data           = DATA_WIDTH'(result_q);
  // Held through the cycle carrying the final label write.
  assign train_mode         = (state_q inside {StTSetup, StTFeat, StTLabel}) | lw_wen_q;
  assign train_sample_wen   = sw_wen_q;
  assign train_sample_addr  = sw_addr_q;
  assign train_sample_data  = sw_data_q;
  assign train_label_wen    = lw_wen_q;
  assign train_label_addr   = lw_addr_q;
  assign train_label_data   = lw_data_q;
  assign classify_start     = (state_q == StCStart);
  assign test_feature_valid = tf_valid_q;
  assign test_feature_data  = tf_data_q;
  assign seq_busy           = (state_q != StIdle);
  assign err                = err_q;

endmodule

// File: tb/tb_knn_host_sequencer.sv
// Directed bench for knn_host_sequencer: a cycle vector table for load and bad headers, plus
// hand-written classify, result back-pressure, timeout and mid-load reset sequences.
module tb_knn_host_sequencer;

  localparam int unsigned TO = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  cfg_num_features;
  logic        train_mode;
  logic        train_sample_wen;
  logic [7:0]  train_sample_addr;
  logic [15:0] train_sample_data;
  logic        train_label_wen;
  logic [7:0]  train_label_addr;
  logic [3:0]  train_label_data;
  logic        classify_start;
  logic        test_feature_valid;
  logic [15:0] test_feature_data;
  logic        classifier_busy;
  logic        classify_done;
  logic [3:0]  result_label;
  logic [2:0]  result_confidence;
  logic        seq_busy;
  logic        err;

  always #5 clk = ~clk;

  knn_host_sequencer #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .cfg_num_features   (cfg_num_features),
    .train_mode         (train_mode),
    .train_sample_wen   (train_sample_wen),
    .train_sample_addr  (train_sample_addr),
    .train_sample_data  (train_sample_data),
    .train_label_wen    (train_label_wen),
    .train_label_addr   (train_label_addr),
    .train_label_data   (train_label_data),
    .classify_start     (classify_start),
    .test_feature_valid (test_feature_valid),
    .test_feature_data  (test_feature_data),
    .classifier_busy    (classifier_busy),
    .classify_done      (classify_done),
    .result_label       (result_label),
    .result_confidence  (result_confidence),
    .seq_busy           (seq_busy),
    .err                (err)
  );

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge.
  int          n_start = 0;
  int          n_tf    = 0;
  logic [15:0] tf_log [64];
  always @(negedge clk) begin
    if (classify_start) n_start <= n_start + 1;
    if (test_feature_valid) begin
      tf_log[n_tf[5:0]] <= test_feature_data;
      n_tf              <= n_tf + 1;
    end
  end

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rdy, tm, bz, er;
    logic        sw;
    logic [7:0]  sa;
    logic [15:0] sd;
    logic        lw;
    logic [7:0]  la;
    logic [3:0]  ld;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic rdy,
                              input logic tm, input logic bz, input logic er, input logic sw,
                              input logic [7:0] sa, input logic [15:0] sd, input logic lw,
                              input logic [7:0] la, input logic [3:0] ld);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.tm = tm; r.bz = bz; r.er = er;
    r.sw = sw; r.sa = sa; r.sd = sd; r.lw = lw; r.la = la; r.ld = ld;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tv [17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_start;
    int base_tf;
    int cnt;
    logic seen_ov;

    // LOAD count=2, cfg=3, then four bad headers (count 0, count 101, opcode 11, opcode 10).
    tv[0]  = mk(1, 16'h0002, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    tv[1]  = mk(1, 16'd10,   0, 1, 1, 0, 0, 0, 0,  0, 0, 0);
    tv[2]  = mk(1, 16'd10,   1, 1, 1, 0, 0, 0, 0,  0, 0, 0);
    tv[3]  = mk(1, 16'd11,   1, 1, 1, 0, 1, 0, 10, 0, 0, 0);
    tv[4]  = mk(1, 16'd12,   1, 1, 1, 0, 1, 1, 11, 0, 0, 0);
    tv[5]  = mk(1, 16'hFFF1, 1, 1, 1, 0, 1, 2, 12, 0, 0, 0);
    tv[6]  = mk(1, 16'd20,   1, 1, 1, 0, 0, 0, 0,  1, 0, 1);
    tv[7]  = mk(1, 16'd21,   1, 1, 1, 0, 1, 3, 20, 0, 0, 0);
    tv[8]  = mk(1, 16'd22,   1, 1, 1, 0, 1, 4, 21, 0, 0, 0);
    tv[9]  = mk(1, 16'h0002, 1, 1, 1, 0, 1, 5, 22, 0, 0, 0);
    tv[10] = mk(0, 16'h0000, 1, 1, 0, 0, 0, 0, 0,  1, 1, 2);
    tv[11] = mk(1, 16'h0000, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    tv[12] = mk(1, 16'h0065, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0);
    tv[13] = mk(1, 16'hC001, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0);
    tv[14] = mk(1, 16'h8003, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0);
    tv[15] = mk(0, 16'h0000, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0);
    tv[16] = mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);

    rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0; cfg_num_features = 4'd3;
    classifier_busy = 0; classify_done = 0; result_label = 0; result_confidence = 0;
    repeat (3) step();
    chk("reset in_ready", in_ready, 0);
    chk("reset outputs",
        {train_mode, train_sample_wen, train_label_wen, classify_start, test_feature_valid,
         seq_busy, err, out_valid}, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("vec%0d in_ready", i), in_ready, tv[i].rdy);
      chk($sformatf("vec%0d train_mode", i), train_mode, tv[i].tm);
      chk($sformatf("vec%0d seq_busy", i), seq_busy, tv[i].bz);
      chk($sformatf("vec%0d err", i), err, tv[i].er);
      chk($sformatf("vec%0d sample_wen", i), train_sample_wen, tv[i].sw);
      chk($sformatf("vec%0d label_wen", i), train_label_wen, tv[i].lw);
      if (tv[i].sw) begin
        chk($sformatf("vec%0d sample_addr", i), train_sample_addr, tv[i].sa);
        chk($sformatf("vec%0d sample_data", i), train_sample_data, tv[i].sd);
      end
      if (tv[i].lw) begin
        chk($sformatf("vec%0d label_addr", i), train_label_addr, tv[i].la);
        chk($sformatf("vec%0d label_data", i), train_label_data, tv[i].ld);
      end
      in_valid = tv[i].v;
      in_data  = tv[i].d;
      step();
    end

    // classify_done while idle must be ignored.
    classify_done = 1; result_label = 4'd9; result_confidence = 3'd2;
    step();
    classify_done = 0;
    step();
    chk("stray done out_valid", out_valid, 0);
    chk("stray done seq_busy", seq_busy, 0);

    // CLASSIFY, cfg=3, busy two cycles after start, features 5,6,7.
    base_start = n_start;
    base_tf    = n_tf;
    in_valid = 1; in_data = 16'h4000;
    step();
    chk("cls start pulse", classify_start, 1);
    chk("cls start in_ready", in_ready, 0);
    cfg_num_features = 4'd1;
    in_data = 16'd5;
    step();
    chk("cls start single", classify_start, 0);
    chk("cls waitbusy in_ready", in_ready, 0);
    step();
    chk("cls waitbusy2 in_ready", in_ready, 0);
    classifier_busy = 1;
    step();
    chk("cls feat in_ready", in_ready, 1);
    step();
    in_data = 16'd6;
    step();
    in_data = 16'd7;
    step();
    in_valid = 0;
    cfg_num_features = 4'd3;
    chk("cls wait in_ready", in_ready, 0);
    step();
    step();
    chk("cls no early out_valid", out_valid, 0);
    classify_done = 1; result_label = 4'd3; result_confidence = 3'd4;
    step();
    classify_done = 0; classifier_busy = 0; result_label = 4'hF; result_confidence = 3'd7;
    chk("cls start count", n_start - base_start, 1);
    chk("cls beat count", n_tf - base_tf, 3);
    chk("cls beat0", tf_log[base_tf[5:0]], 16'd5);
    chk("cls beat1", tf_log[6'(base_tf + 1)], 16'd6);
    chk("cls beat2", tf_log[6'(base_tf + 2)], 16'd7);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("result hold%0d valid", i), out_valid, 1);
      chk($sformatf("result hold%0d data", i), out_data, 16'h0043);
      step();
    end
    out_ready = 1;
    chk("result final valid", out_valid, 1);
    step();
    out_ready = 0;
    chk("result released", out_valid, 0);
    chk("idle after result", seq_busy, 0);
    chk("idle ready", in_ready, 1);

    // New header right away; no classify_done ever, so it must time out.
    in_valid = 1; in_data = 16'h4000;
    step();
    in_valid = 0;
    chk("timeout hdr accepted", classify_start, 1);
    step();
    cnt = 0;
    seen_ov = 0;
    while (!err && cnt < int'(TO) + 20) begin
      step();
      cnt++;
      if (out_valid) seen_ov = 1;
    end
    chk("timeout latency", cnt, TO);
    chk("timeout out_valid", seen_ov, 0);
    chk("timeout idle", seq_busy, 0);
    step();
    chk("timeout err one cycle", err, 0);

    // Reset in the middle of a 3-sample load.
    in_valid = 1; in_data = 16'h0003;
    step();
    in_data = 16'd100;
    step();
    step();
    in_data = 16'd101;
    step();
    chk("midload train_mode", train_mode, 1);
    chk("midload sample_wen", train_sample_wen, 1);
    rst_n = 0;
    step();
    chk("midreset outputs",
        {train_mode, train_sample_wen, train_label_wen, classify_start, test_feature_valid,
         seq_busy, err, out_valid}, 0);
    chk("midreset in_ready", in_ready, 0);
    rst_n = 1; in_valid = 0;
    cnt = 0;
    while (!in_ready && cnt < 10) begin
      step();
      cnt++;
    end
    chk("ready after reset", in_ready, 1);
    cfg_num_features = 4'd2;
    in_valid = 1; in_data = 16'h0001;
    step();
    in_data = 16'd7;
    step();
    step();
    chk("reload wen0", train_sample_wen, 1);
    chk("reload addr0", train_sample_addr, 0);
    chk("reload data0", train_sample_data, 16'd7);
    in_data = 16'd8;
    step();
    chk("reload addr1", train_sample_addr, 1);
    chk("reload data1", train_sample_data, 16'd8);
    in_data = 16'd5;
    step();
    in_valid = 0;
    chk("reload label_wen", train_label_wen, 1);
    chk("reload label", {train_label_addr, 4'h0, train_label_data}, {8'd0, 4'h0, 4'd5});
    chk("reload train_mode", train_mode, 1);
    step();
    chk("reload train_mode off", train_mode, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
